// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end definitions: fetch FSM encoding, instruction size, reset vector.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rv32i_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } fetch_state_t;

  localparam int unsigned INSTR_BYTES = 4;

  // Same default as the program-counter block so both agree on the boot address.
  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_unit_if.sv
// Fetch unit bundle: instruction memory port, execute redirect, decode handshake.
// Latency: n/a (wiring only). Optional perf counter outputs exist when IF_PERF_CNT_EN is defined.
// Backpressure: decode via instr_ready, memory via imem_gnt.
interface if_fetch_unit_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc, perf_fetch_cnt, perf_stall_cnt,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc, perf_fetch_cnt, perf_stall_cnt,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
`else
  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
`endif

endinterface

// File: rtl/if_out_reg.sv
// Single-entry valid/ready holding register for fetched instruction + PC, with flush.
// Latency: 1 cycle from load to valid.
// Backpressure: payload held while valid && !ready; loads are only issued when empty.
module if_out_reg #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [XLEN-1:0] load_instr,
  input  logic [XLEN-1:0] load_pc,
  input  logic            flush,
  input  logic            ready,
  output logic            valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc
);

  // occupancy: flush beats load beats consume
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                valid <= 1'b0;
    else if (flush)          valid <= 1'b0;
    else if (load)           valid <= 1'b1;
    else if (valid && ready) valid <= 1'b0;
  end

  // payload only changes on load, so it stays stable under backpressure
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr <= '0;
      pc    <= '0;
    end else if (load) begin
      instr <= load_instr;
      pc    <= load_pc;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// RV32I fetch: owns fetch PC, one outstanding imem read, hands instr+PC to decode. Optional IF_PERF_CNT_EN.
// Latency: first request 2nd cycle after reset; 1 instr per 3 cycles peak with 1-cycle memory.
// Backpressure: no request while the output register is full; redirect suppresses the request.
module if_fetch_unit
  import rv32i_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int          XLEN         = 32
) (
  input  logic             clk,
  input  logic             rst,
  if_fetch_unit_if.master  bus
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] fetch_pc, fetch_pc_nxt;
  logic            discard, discard_nxt;
  logic            req;
  logic            load;
  logic            out_valid;

  // FSM state, fetch PC and stale-response flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      fetch_pc <= RESET_VECTOR;
      discard  <= 1'b0;
    end else begin
      state    <= state_nxt;
      fetch_pc <= fetch_pc_nxt;
      discard  <= discard_nxt;
    end
  end

  // next state, request, response capture; redirect overrides the PC last
  always_comb begin
    state_nxt    = state;
    fetch_pc_nxt = fetch_pc;
    discard_nxt  = discard;
    req          = 1'b0;
    load         = 1'b0;
    case (state)
      S_IDLE: state_nxt = S_REQ;
      S_REQ: begin
        req = !out_valid && !bus.redirect_valid;
        if (req && bus.imem_gnt) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (bus.imem_rvalid) begin
          state_nxt   = S_REQ;
          discard_nxt = 1'b0;
          // a response racing a redirect belongs to the old path
          if (!discard && !bus.redirect_valid) begin
            load         = 1'b1;
            fetch_pc_nxt = fetch_pc + XLEN'(INSTR_BYTES);
          end
        end else if (bus.redirect_valid) begin
          discard_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (bus.redirect_valid) fetch_pc_nxt = bus.redirect_pc & ~XLEN'(3);
  end

  if_out_reg #(.XLEN(XLEN)) u_out_reg (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_instr (bus.imem_rdata),
    .load_pc    (fetch_pc),
    .flush      (bus.redirect_valid),
    .ready      (bus.instr_ready),
    .valid      (out_valid),
    .instr      (bus.instr),
    .pc         (bus.instr_pc)
  );

  assign bus.imem_req    = req;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = out_valid;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] stall_cnt;

  // transfer and stall counters, wrapping, independent of redirect
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && bus.instr_ready)  fetch_cnt <= fetch_cnt + 32'd1;
      if (out_valid && !bus.instr_ready) stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign bus.perf_fetch_cnt = fetch_cnt;
  assign bus.perf_stall_cnt = stall_cnt;
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Self-checking bench for if_fetch_unit: memory model, PC-sequence scoreboard, directed corners.
// Latency: n/a.
// Backpressure: decode ready and memory grant driven randomly or per scenario.
module tb_if_fetch_unit;
  import rv32i_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_fetch_unit_if bus ();

  if_fetch_unit #(.RESET_VECTOR(32'h0000_0000), .XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // stimulus knobs
  int          gnt_pct = 100;
  int          lat_min = 1;
  int          lat_max = 1;
  logic        rdy = 1'b1;
  logic        redir = 1'b0;
  logic [31:0] redir_pc = '0;
  logic        extra_rvalid = 1'b0;

  // memory model: one pending read with a countdown
  bit          pend = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;

  // reference: next PC decode should see
  logic [31:0] exp_pc = '0;
  int          delivered = 0;

  // per-step samples
  logic        s_req, s_rvalid, s_valid;
  logic [31:0] s_addr, s_instr, s_pc;
  bit          acc, delv, valid_seen;

  typedef struct {
    logic [31:0] target;
    int          lat;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } redir_vec_t;
  redir_vec_t tbl [4];

  function automatic logic [31:0] mem_word(logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out waiting, expected event within bound", name);
  endtask

  // one clock cycle: drive at negedge, sample, update model, wait next negedge
  task automatic step();
    bus.instr_ready    = rdy;
    bus.redirect_valid = redir;
    bus.redirect_pc    = redir_pc;
    bus.imem_gnt       = ($urandom_range(99) < 32'(gnt_pct));
    bus.imem_rvalid    = extra_rvalid || (pend && pend_cnt == 0);
    bus.imem_rdata     = extra_rvalid ? 32'hDEAD_BEEF :
                         (pend && pend_cnt == 0) ? mem_word(pend_addr) : $urandom;
    #1;
    s_req    = bus.imem_req;
    s_addr   = bus.imem_addr;
    s_rvalid = bus.imem_rvalid;
    s_valid  = bus.instr_valid;
    s_instr  = bus.instr;
    s_pc     = bus.instr_pc;
    acc      = s_req && bus.imem_gnt;
    delv     = 0;
    if (s_valid) valid_seen = 1;
    if (s_req) begin
      check("req_aligned", {30'd0, s_addr[1:0]}, 32'd0);
      check("one_outstanding", 32'(pend), 32'd0);
    end
    if (redir) begin
      check("redirect_blocks_req", 32'(s_req), 32'd0);
      exp_pc = redir_pc & ~32'd3;
    end else begin
      if (s_valid && rdy) begin
        check("deliver_pc", s_pc, exp_pc);
        check("deliver_instr", s_instr, mem_word(exp_pc));
        exp_pc += 32'd4;
        delivered++;
        delv = 1;
      end
      if (acc) check("req_addr", s_addr, exp_pc);
    end
    if (s_rvalid) pend = 0;
    else if (pend) pend_cnt--;
    if (acc) begin
      pend      = 1;
      pend_addr = s_addr;
      pend_cnt  = int'($urandom_range(lat_max, lat_min)) - 1;
    end
    extra_rvalid = 0;
    redir        = 0;
    @(negedge clk);
  endtask

  task automatic run_until_accept(string name);
    for (int k = 0; k < 60; k++) begin
      step();
      if (acc) return;
    end
    timeout_fail(name);
  endtask

  task automatic run_until_deliver(string name, output logic [31:0] pc);
    pc = 'x;
    for (int k = 0; k < 80; k++) begin
      step();
      if (delv) begin
        pc = s_pc;
        return;
      end
    end
    timeout_fail(name);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] pc0, held_pc, held_instr;

    tbl[0] = '{32'h0000_0103, 4, 32'h0000_0100, 32'h0000_0104};
    tbl[1] = '{32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 32'h0000_0000};
    tbl[2] = '{32'h0000_2002, 2, 32'h0000_2000, 32'h0000_2004};
    tbl[3] = '{32'h0000_0007, 3, 32'h0000_0004, 32'h0000_0008};

    bus.instr_ready = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    // reset values
    check("rst_req", 32'(bus.imem_req), 32'd0);
    check("rst_valid", 32'(bus.instr_valid), 32'd0);
    check("rst_instr", bus.instr, 32'd0);
    check("rst_instr_pc", bus.instr_pc, 32'd0);
    check("rst_addr", bus.imem_addr, 32'd0);

    // first request lands in the 2nd cycle, then 0,4,8 in order
    rst = 1'b1;
    exp_pc = 32'h0;
    step();
    check("cycle1_req", 32'(s_req), 32'd0);
    step();
    check("cycle2_req", 32'(s_req), 32'd1);
    check("cycle2_addr", s_addr, 32'h0);
    run_until_deliver("seq0", pc0); check("seq_pc0", pc0, 32'h0);
    run_until_deliver("seq1", pc0); check("seq_pc1", pc0, 32'h4);
    run_until_deliver("seq2", pc0); check("seq_pc2", pc0, 32'h8);

    // decode stall: payload held, no requests, then resume at pc+4
    rdy = 1'b0;
    begin : wait_valid
      for (int k = 0; k < 60; k++) begin
        step();
        if (s_valid) disable wait_valid;
      end
      timeout_fail("stall_wait_valid");
    end
    held_pc = s_pc;
    held_instr = s_instr;
    for (int k = 0; k < 5; k++) begin
      step();
      check("stall_valid", 32'(s_valid), 32'd1);
      check("stall_instr", s_instr, held_instr);
      check("stall_pc", s_pc, held_pc);
      check("stall_req", 32'(s_req), 32'd0);
    end
    rdy = 1'b1;
    run_until_accept("stall_resume");
    check("stall_next_addr", s_addr, held_pc + 32'd4);

    // redirect on the same cycle as rvalid: response never presented
    lat_min = 1; lat_max = 1;
    run_until_accept("same_cycle_acc");
    redir = 1'b1; redir_pc = 32'h0000_0040;
    step();
    check("same_cycle_rvalid", 32'(s_rvalid), 32'd1);
    valid_seen = 0;
    run_until_accept("same_cycle_next");
    check("same_cycle_no_valid", 32'(valid_seen), 32'd0);
    check("same_cycle_addr", s_addr, 32'h0000_0040);

    // table of redirects issued right after a request is granted
    for (int i = 0; i < 4; i++) begin
      lat_min = tbl[i].lat; lat_max = tbl[i].lat;
      run_until_accept("tbl_acc");
      redir = 1'b1; redir_pc = tbl[i].target;
      step();
      run_until_accept("tbl_next_acc");
      check("tbl_req_addr", s_addr, tbl[i].exp0);
      run_until_deliver("tbl_d0", pc0); check("tbl_pc0", pc0, tbl[i].exp0);
      run_until_deliver("tbl_d1", pc0); check("tbl_pc1", pc0, tbl[i].exp1);
    end

    // async reset while waiting on memory, then a late response
    lat_min = 4; lat_max = 4;
    run_until_accept("arst_acc");
    step();
    #2 rst = 1'b0;
    #1;
    check("arst_req", 32'(bus.imem_req), 32'd0);
    check("arst_valid", 32'(bus.instr_valid), 32'd0);
    check("arst_instr", bus.instr, 32'd0);
    check("arst_instr_pc", bus.instr_pc, 32'd0);
    check("arst_addr", bus.imem_addr, 32'd0);
    repeat (2) @(negedge clk);
    pend = 0; exp_pc = 32'h0;
    lat_min = 1; lat_max = 1;
    rst = 1'b1;
    extra_rvalid = 1'b1;
    valid_seen = 0;
    repeat (3) step();
    check("late_rvalid_no_valid", 32'(valid_seen), 32'd0);
    run_until_deliver("arst_d0", pc0); check("arst_pc0", pc0, 32'h0);

    // random traffic against the scoreboard
    gnt_pct = 70; lat_min = 1; lat_max = 4;
    delivered = 0;
    for (int k = 0; k < 3000; k++) begin
      rdy = ($urandom_range(9) < 7);
      if ($urandom_range(99) < 3) begin
        redir = 1'b1;
        redir_pc = $urandom;
      end
      step();
    end
    check("random_progress", 32'(delivered > 100), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
